crc32_frame_checker: RTL and testbench

//  Receive-side CRC-32 checker; counterpart of the CRC generator datapath in top.
//  - Consumes a framed 32-bit word stream: data beats, then one trailing beat carrying the sender's CRC.
//  - Recomputes CRC-32 over the data bytes, compares it with the received CRC and reports one verdict per frame.
//  - Sits between the SRAM read-out / link ingress and the host status logic.

---
 rtl/crc_pkg.sv | 25 ++
 rtl/crc32_word_update.sv | 21 ++
 rtl/crc32_frame_checker.sv | 127 ++++++++++++
 tb/tb_crc32_frame_checker.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// CRC-32/ISO-HDLC constants, checker state encoding and a single-byte
// reflected CRC update shared by the datapath.
package crc_pkg;

   localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_XOROUT    = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      S_DATA,
      S_CRC,
      S_RES
   } state_t;

   // Fold one byte into a reflected CRC, LSB first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
      logic [31:0] c;
      c = crc ^ {24'h00_0000, b};
      for (int unsigned i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc32_word_update.sv
// Combinational CRC-32 update over byte lanes 0..nbytes_m1 of one word.
module crc32_word_update
   import crc_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [31:0] data,
   input  logic [1:0]  nbytes_m1,
   output logic [31:0] crc_out
);

   // Chain the byte update over the active lanes, lane 0 first.
   always_comb begin
      crc_out = crc_in;
      for (int unsigned i = 0; i < 4; i++) begin
         if (i <= 32'(nbytes_m1)) begin
            crc_out = crc32_byte(crc_out, data[8*i +: 8]);
         end
      end
   end

endmodule

// File: rtl/crc32_frame_checker.sv
// Receive-side CRC-32 frame checker: folds data beats into a running CRC,
// compares against the trailing CRC beat and reports one verdict per frame.
module crc32_frame_checker
   import crc_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WORDS  = 512,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   input  logic [1:0]            in_nbytes_m1,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic                  res_ok,
   output logic                  res_len_err,
   output logic [DATA_WIDTH-1:0] res_crc,
   output logic [9:0]            res_words,
   output logic [CNT_WIDTH-1:0]  frames_ok,
   output logic [CNT_WIDTH-1:0]  frames_bad
);

   localparam logic [9:0] MAX_W = 10'(MAX_WORDS);

   state_t               state_q;
   logic [31:0]          crc_q;
   logic [9:0]           words_q;
   logic                 len_err_q;
   logic                 res_ok_q;
   logic                 res_len_err_q;
   logic [31:0]          res_crc_q;
   logic [9:0]           res_words_q;
   logic [CNT_WIDTH-1:0] frames_ok_q;
   logic [CNT_WIDTH-1:0] frames_bad_q;

   logic [31:0] crc_upd;
   logic [1:0]  lanes_m1;
   logic        beat;
   logic        res_take;
   logic        crc_match;
   logic        verdict_ok;

   // Handshakes and per-beat decode; all outputs come from registers.
   always_comb begin
      in_ready    = (state_q != S_RES);
      res_valid   = (state_q == S_RES);
      beat        = in_valid && in_ready;
      res_take    = res_valid && res_ready;
      lanes_m1    = in_last ? in_nbytes_m1 : 2'd3;
      crc_match   = (in_data == (crc_q ^ CRC_XOROUT));
      verdict_ok  = crc_match && !len_err_q;
      res_ok      = res_ok_q;
      res_len_err = res_len_err_q;
      res_crc     = res_crc_q;
      res_words   = res_words_q;
      frames_ok   = frames_ok_q;
      frames_bad  = frames_bad_q;
   end

   crc32_word_update u_word (
      .crc_in    (crc_q),
      .data      (in_data),
      .nbytes_m1 (lanes_m1),
      .crc_out   (crc_upd)
   );

   // Frame FSM, length check, verdict latch and saturating counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_DATA;
         crc_q         <= CRC_INIT;
         words_q       <= '0;
         len_err_q     <= 1'b0;
         res_ok_q      <= 1'b0;
         res_len_err_q <= 1'b0;
         res_crc_q     <= '0;
         res_words_q   <= '0;
         frames_ok_q   <= '0;
         frames_bad_q  <= '0;
      end else begin
         case (state_q)
            S_DATA: begin
               if (beat) begin
                  crc_q <= crc_upd;
                  // Count saturates at MAX_WORDS; the next beat flags the overrun.
                  if (words_q == MAX_W) begin
                     len_err_q <= 1'b1;
                  end else begin
                     words_q <= words_q + 10'd1;
                  end
                  if (in_last) begin
                     state_q <= S_CRC;
                  end
               end
            end
            S_CRC: begin
               if (beat) begin
                  res_crc_q     <= crc_q ^ CRC_XOROUT;
                  res_ok_q      <= verdict_ok;
                  res_len_err_q <= len_err_q;
                  res_words_q   <= words_q;
                  if (verdict_ok) begin
                     if (frames_ok_q != '1) frames_ok_q <= frames_ok_q + CNT_WIDTH'(1);
                  end else begin
                     if (frames_bad_q != '1) frames_bad_q <= frames_bad_q + CNT_WIDTH'(1);
                  end
                  state_q <= S_RES;
               end
            end
            S_RES: begin
               if (res_take) begin
                  crc_q     <= CRC_INIT;
                  words_q   <= '0;
                  len_err_q <= 1'b0;
                  state_q   <= S_DATA;
               end
            end
            default: state_q <= S_DATA;
         endcase
      end
   end

endmodule

// File: tb/tb_crc32_frame_checker.sv
// Bench for crc32_frame_checker: fixed vectors, stall/reset sequences and
// random frames against a table-lookup CRC model.
module tb_crc32_frame_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, in_last, res_ready, sel;
   logic [31:0] in_data;
   logic [1:0]  in_nbytes_m1;

   logic        a_in_ready, a_res_valid, a_res_ok, a_res_len_err;
   logic [31:0] a_res_crc;
   logic [9:0]  a_res_words;
   logic [15:0] a_frames_ok, a_frames_bad;
   logic        b_in_ready, b_res_valid, b_res_ok, b_res_len_err;
   logic [31:0] b_res_crc;
   logic [9:0]  b_res_words;
   logic [15:0] b_frames_ok, b_frames_bad;

   logic        m_in_ready, m_res_valid, m_res_ok, m_res_len_err;
   logic [31:0] m_res_crc;
   logic [9:0]  m_res_words;
   logic [15:0] m_frames_ok, m_frames_bad;

   crc32_frame_checker #(.DATA_WIDTH(32), .MAX_WORDS(512), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid && !sel), .in_ready(a_in_ready), .in_data(in_data),
      .in_last(in_last), .in_nbytes_m1(in_nbytes_m1),
      .res_valid(a_res_valid), .res_ready(res_ready && !sel),
      .res_ok(a_res_ok), .res_len_err(a_res_len_err), .res_crc(a_res_crc),
      .res_words(a_res_words), .frames_ok(a_frames_ok), .frames_bad(a_frames_bad)
   );

   crc32_frame_checker #(.DATA_WIDTH(32), .MAX_WORDS(4), .CNT_WIDTH(16)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid && sel), .in_ready(b_in_ready), .in_data(in_data),
      .in_last(in_last), .in_nbytes_m1(in_nbytes_m1),
      .res_valid(b_res_valid), .res_ready(res_ready && sel),
      .res_ok(b_res_ok), .res_len_err(b_res_len_err), .res_crc(b_res_crc),
      .res_words(b_res_words), .frames_ok(b_frames_ok), .frames_bad(b_frames_bad)
   );

   always_comb begin
      m_in_ready    = sel ? b_in_ready    : a_in_ready;
      m_res_valid   = sel ? b_res_valid   : a_res_valid;
      m_res_ok      = sel ? b_res_ok      : a_res_ok;
      m_res_len_err = sel ? b_res_len_err : a_res_len_err;
      m_res_crc     = sel ? b_res_crc     : a_res_crc;
      m_res_words   = sel ? b_res_words   : a_res_words;
      m_frames_ok   = sel ? b_frames_ok   : a_frames_ok;
      m_frames_bad  = sel ? b_frames_bad  : a_frames_bad;
   end

   int n_tests = 0;
   int n_fail  = 0;
   int exp_ok_a = 0, exp_bad_a = 0, exp_ok_b = 0, exp_bad_b = 0;
   logic [31:0] crc_tbl [256];

   typedef logic [7:0] bq_t[$];

   typedef struct {
      logic [31:0] d [3];
      int          nbeats;
      logic [1:0]  nb;
      logic [31:0] crcbeat;
      bit          ok;
      logic [31:0] crc;
      int          words;
   } vec_t;

   vec_t vecs [3];

   function automatic logic [31:0] ref_crc(input bq_t b);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      foreach (b[i]) c = crc_tbl[c[7:0] ^ b[i]] ^ (c >> 8);
      return ~c;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_beat(input logic [31:0] d, input logic last, input logic [1:0] nb);
      int budget = 0;
      in_valid = 1'b1; in_data = d; in_last = last; in_nbytes_m1 = nb;
      while (!m_in_ready && budget < 100) begin
         @(posedge clk); #1; budget++;
      end
      if (!m_in_ready) begin
         n_tests++; n_fail++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = $urandom; in_last = 1'($urandom); in_nbytes_m1 = 2'($urandom);
   endtask

   task automatic get_res(input string name, input bit ok, input bit len_err,
                          input logic [31:0] crc, input int words,
                          input int fok, input int fbad, input int delay);
      int budget = 0;
      while (!m_res_valid && budget < 100) begin
         @(posedge clk); #1; budget++;
      end
      check({name, "_valid"}, 32'(m_res_valid), 32'd1);
      check({name, "_ok"}, 32'(m_res_ok), 32'(ok));
      check({name, "_len_err"}, 32'(m_res_len_err), 32'(len_err));
      check({name, "_crc"}, m_res_crc, crc);
      check({name, "_words"}, 32'(m_res_words), 32'(words));
      check({name, "_frames_ok"}, 32'(m_frames_ok), 32'(fok));
      check({name, "_frames_bad"}, 32'(m_frames_bad), 32'(fbad));
      repeat (delay) begin @(posedge clk); #1; end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      check({name, "_valid_drop"}, 32'(m_res_valid), 32'd0);
   endtask

   task automatic send_frame(input bq_t bytes, input logic [31:0] crcbeat, input int gap_max);
      int nbeats;
      logic [31:0] w;
      nbeats = (bytes.size() + 3) / 4;
      for (int bt = 0; bt < nbeats; bt++) begin
         w = $urandom;
         for (int l = 0; l < 4; l++) begin
            if (bt * 4 + l < bytes.size()) w[8*l +: 8] = bytes[bt * 4 + l];
         end
         if (bt == nbeats - 1) send_beat(w, 1'b1, 2'((bytes.size() - 1) % 4));
         else                  send_beat(w, 1'b0, 2'($urandom));
         repeat ($urandom_range(gap_max, 0)) @(posedge clk);
         #1;
      end
      send_beat(crcbeat, 1'($urandom), 2'($urandom));
   endtask

   task automatic run_frame(input string name, input bq_t bytes, input bit corrupt,
                            input int max_w, input int gap_max, input int delay);
      logic [31:0] crc, beat;
      int nbeats, words;
      bit len_err, ok;
      crc     = ref_crc(bytes);
      beat    = corrupt ? (crc ^ (32'd1 << $urandom_range(31, 0))) : crc;
      nbeats  = (bytes.size() + 3) / 4;
      len_err = nbeats > max_w;
      words   = len_err ? max_w : nbeats;
      ok      = !corrupt && !len_err;
      if (sel) begin if (ok) exp_ok_b++; else exp_bad_b++; end
      else     begin if (ok) exp_ok_a++; else exp_bad_a++; end
      send_frame(bytes, beat, gap_max);
      get_res(name, ok, len_err, crc, words,
              sel ? exp_ok_b : exp_ok_a, sel ? exp_bad_b : exp_bad_a, delay);
   endtask

   function automatic bq_t rand_bytes(input int n);
      bq_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   initial begin
      logic [31:0] c;
      bq_t q;
      for (int n = 0; n < 256; n++) begin
         c = 32'(n);
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
         crc_tbl[n] = c;
      end

      vecs[0] = '{d: '{32'h3433_3231, 32'h3837_3635, 32'h0000_0039}, nbeats: 3, nb: 2'd0,
                  crcbeat: 32'hCBF4_3926, ok: 1'b1, crc: 32'hCBF4_3926, words: 3};
      vecs[1] = '{d: '{32'h3433_3231, 32'h3837_3635, 32'h0000_0039}, nbeats: 3, nb: 2'd0,
                  crcbeat: 32'hCBF4_3927, ok: 1'b0, crc: 32'hCBF4_3926, words: 3};
      vecs[2] = '{d: '{32'h0000_0000, 32'h0, 32'h0}, nbeats: 1, nb: 2'd3,
                  crcbeat: 32'h2144_DF1C, ok: 1'b1, crc: 32'h2144_DF1C, words: 1};

      sel = 1'b0; rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
      in_nbytes_m1 = '0; res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_in_ready", 32'(a_in_ready), 32'd1);
      check("rst_res_valid", 32'(a_res_valid), 32'd0);
      check("rst_res_crc", a_res_crc, 32'd0);
      check("rst_frames_ok", 32'(a_frames_ok), 32'd0);

      // Fixed vectors
      foreach (vecs[v]) begin
         for (int bt = 0; bt < vecs[v].nbeats; bt++) begin
            send_beat(vecs[v].d[bt], bt == vecs[v].nbeats - 1,
                      (bt == vecs[v].nbeats - 1) ? vecs[v].nb : 2'd3);
         end
         send_beat(vecs[v].crcbeat, 1'b0, 2'd0);
         if (vecs[v].ok) exp_ok_a++; else exp_bad_a++;
         get_res($sformatf("vec%0d", v), vecs[v].ok, 1'b0, vecs[v].crc, vecs[v].words,
                 exp_ok_a, exp_bad_a, 0);
      end

      // Result held back while the next frame's first beat waits
      send_beat(32'h3433_3231, 1'b0, 2'd0);
      send_beat(32'h3837_3635, 1'b0, 2'd0);
      send_beat(32'h0000_0039, 1'b1, 2'd0);
      send_beat(32'hCBF4_3926, 1'b0, 2'd0);
      exp_ok_a++;
      in_valid = 1'b1; in_data = 32'h3433_3231; in_last = 1'b0; in_nbytes_m1 = 2'd3;
      for (int i = 0; i < 5; i++) begin
         check("hold_in_ready", 32'(a_in_ready), 32'd0);
         check("hold_res_valid", 32'(a_res_valid), 32'd1);
         check("hold_res_crc", a_res_crc, 32'hCBF4_3926);
         check("hold_res_words", 32'(a_res_words), 32'd3);
         @(posedge clk); #1;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      send_beat(32'h3433_3231, 1'b0, 2'd3);
      send_beat(32'h3837_3635, 1'b0, 2'd3);
      send_beat(32'hAA55_0039, 1'b1, 2'd0);
      send_beat(32'hCBF4_3926, 1'b1, 2'd0);
      exp_ok_a++;
      get_res("after_hold", 1'b1, 1'b0, 32'hCBF4_3926, 3, exp_ok_a, exp_bad_a, 0);
      q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      run_frame("b2b", q, 1'b0, 512, 0, 0);

      // Length limit on the MAX_WORDS=4 instance
      sel = 1'b1;
      run_frame("len6", rand_bytes(24), 1'b0, 4, 0, 0);
      run_frame("len4", rand_bytes(16), 1'b0, 4, 0, 0);
      run_frame("len5", rand_bytes(17), 1'b0, 4, 1, 1);
      sel = 1'b0;

      // Random frames
      for (int f = 0; f < 40; f++) begin
         run_frame($sformatf("rnd%0d", f), rand_bytes($urandom_range(32, 1)),
                   ($urandom_range(3, 0) == 0), 512, 2, $urandom_range(3, 0));
      end

      // Reset in the middle of a frame
      send_beat(32'h3433_3231, 1'b0, 2'd3);
      send_beat(32'h3837_3635, 1'b0, 2'd3);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_ok_a = 0; exp_bad_a = 0;
      check("mrst_in_ready", 32'(a_in_ready), 32'd1);
      check("mrst_res_valid", 32'(a_res_valid), 32'd0);
      check("mrst_res_ok", 32'(a_res_ok), 32'd0);
      check("mrst_res_len_err", 32'(b_res_len_err), 32'd0);
      check("mrst_res_crc", a_res_crc, 32'd0);
      check("mrst_res_words", 32'(a_res_words), 32'd0);
      check("mrst_frames_bad", 32'(a_frames_bad), 32'd0);
      check("mrst_b_frames_bad", 32'(b_frames_bad), 32'd0);
      run_frame("post_rst", q, 1'b0, 512, 0, 0);
      repeat (3) @(posedge clk);
      #1 check("post_rst_no_extra", 32'(a_res_valid), 32'd0);
      check("post_rst_frames_ok", 32'(a_frames_ok), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
